// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [2:0] {
    StRun      = 3'd0,
    StLuStall  = 3'd1,
    StImemWait = 3'd2,
    StDmemWait = 3'd3
  } hz_state_t;

  localparam int unsigned REG_ZERO = 0;

  // addi x0, x0, 0: what the pipeline registers hold after a flush or bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Operand/destination info, branch and memory handshakes in; pipeline enables out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  imem_valid;
  logic                  mem_req;
  logic                  mem_ready;

  logic                  pc_en;
  logic                  ifid_en;
  logic                  ifid_flush;
  logic                  idex_bubble;
  logic                  back_en;
  logic [2:0]            state_o;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_valid, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, back_en, state_o
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, imem_valid, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_bubble, back_en, state_o
  );

endinterface

// File: rtl/pipe_hazard_ctrl_lu_hazard_det.sv
// Load-use hazard comparator: a load in EX writing a register the ID instruction reads.
module lu_hazard_det
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  output logic                  hazard_o
);

  logic rd_nonzero;
  logic rs1_match;
  logic rs2_match;

  always_comb begin
    rd_nonzero = (ex_rd_i != REG_ADDR_W'(REG_ZERO));
    rs1_match  = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_match  = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    hazard_o   = ex_mem_read_i && rd_nonzero && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-half pipeline sequencer: PC/IF-ID/ID-EX/back-end controls from hazards and misses.
// Optional performance counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_W     = 5,
`ifdef PIPE_HAZARD_PERF_EN
  parameter int unsigned CNT_W          = 32,
`endif
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input  logic               clk,
  input  logic               reset,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count,
`endif
  pipe_hazard_ctrl_if.slave  bus
);

  hz_state_t  state_q, state_d;
  logic [1:0] lu_cnt_q, lu_cnt_d;
  logic       lu_hazard;
  logic       dmiss;
  logic       pc_en, ifid_en, ifid_flush, idex_bubble, back_en;

  lu_hazard_det #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_lu_det (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_use_rs1_i  (bus.id_use_rs1),
    .id_use_rs2_i  (bus.id_use_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_mem_read),
    .hazard_o      (lu_hazard)
  );

  assign dmiss = bus.mem_req && !bus.mem_ready;

  // RUN, IMEM_WAIT and a completing DMEM_WAIT all share the RUN evaluation rules.
  always_comb begin
    state_d     = state_q;
    lu_cnt_d    = lu_cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    back_en     = 1'b1;
    if (reset) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      back_en     = 1'b0;
      state_d     = StRun;
      lu_cnt_d    = 2'd0;
    end else if (dmiss) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      back_en  = 1'b0;
      state_d  = StDmemWait;
      lu_cnt_d = 2'd0;
    end else if (bus.ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = StRun;
      lu_cnt_d    = 2'd0;
    end else if (state_q == StLuStall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      lu_cnt_d    = lu_cnt_q - 2'd1;
      if (lu_cnt_q <= 2'd1) begin
        state_d = StRun;
      end
    end else if (lu_hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      if (LOAD_USE_STALL > 1) begin
        state_d  = StLuStall;
        lu_cnt_d = 2'(LOAD_USE_STALL - 1);
      end else begin
        state_d = StRun;
      end
    end else if (!bus.imem_valid) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      state_d    = StImemWait;
    end else begin
      state_d = StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      lu_cnt_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.back_en     = back_en;
  assign bus.state_o     = state_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!reset && !pc_en) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (!reset && !dmiss && bus.ex_branch_taken) begin
      flush_d = flush_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the front half of the 5-stage integer pipeline.
- Generates PC-write, IF/ID enable/flush, ID/EX bubble and back-end freeze controls.
- Inputs: ID-stage operand info, EX-stage destination info, branch resolution and memory handshakes.
- Placement: between fetch, decode and memory interfaces. Drives the IF/ID pipeline register's enable and flush, and the PC register's enable.

Parameters:
- REG_ADDR_W, 5, register-specifier width; register 0 is hardwired zero and never causes a hazard.
- LOAD_USE_STALL, 1, stall cycles inserted for a load-use dependency; legal range 1..3.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  REG_ADDR_W  source register 1 of the instruction in ID
- id_rs2  in  REG_ADDR_W  source register 2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  REG_ADDR_W  destination of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch or jump this cycle
- imem_valid  in  1  fetch data valid this cycle
- mem_req  in  1  MEM stage has an active data access
- mem_ready  in  1  data access completes this cycle
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  load a NOP into IF/ID; overrides ifid_en
- idex_bubble  out  1  load a NOP into ID/EX
- back_en  out  1  enable for the ID/EX, EX/MEM and MEM/WB registers
- state_o  out  3  current FSM state, debug only
- stall_cycles  out  CNT_W  present only with the optional feature
- flush_count  out  CNT_W  present only with the optional feature

Behaviour:
- States: RUN=0, LU_STALL=1, IMEM_WAIT=2, DMEM_WAIT=3. The state register is the only state apart from the LU counter (2 bits). Outputs are combinational from state and inputs.
- While reset is high: state<=RUN, counter<=0. Outputs are pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, back_en=0. Reset mid-stall aborts the stall immediately.
- Hazard definition: lu_hazard = ex_mem_read AND ex_rd!=0 AND ((id_use_rs1 AND id_rs1==ex_rd) OR (id_use_rs2 AND id_rs2==ex_rd)).
- Priority, highest first: data miss, branch redirect, load-use, fetch miss.
- Data miss:
  - Condition: mem_req AND NOT mem_ready, in any state.
  - Response: all enables 0 and no flush or bubble; the whole pipe freezes.
  - Enter DMEM_WAIT and stay until mem_ready=1.
  - The mem_ready cycle itself is a normal RUN cycle with all enables 1. Its outputs are evaluated with RUN rules, and the FSM returns to RUN.
  - Any pending LU count is lost; the hazard is re-evaluated afresh.
- Branch redirect: ex_branch_taken=1 and no data miss.
  - Outputs: pc_en=1, ifid_flush=1, idex_bubble=1, back_en=1.
  - Next state is RUN, even from LU_STALL or IMEM_WAIT.
  - Penalty is exactly 2 killed instructions.
- Load-use in RUN:
  - Outputs: pc_en=0, ifid_en=0, idex_bubble=1, back_en=1.
  - If LOAD_USE_STALL>1, go to LU_STALL with counter=LOAD_USE_STALL-1. Otherwise stay in RUN.
- LU_STALL:
  - Outputs are the same as for load-use.
  - Counter decrements each cycle; at counter==1, next state is RUN.
  - Total stall is exactly LOAD_USE_STALL cycles.
- Fetch miss: imem_valid=0 in RUN with no higher-priority event.
  - Outputs: pc_en=0, ifid_flush=1, back_en=1, idex_bubble=0.
  - Go to IMEM_WAIT and remain until imem_valid=1. That cycle is normal (pc_en=1, ifid_en=1) and the FSM returns to RUN.
- Normal RUN cycle: pc_en=ifid_en=back_en=1, ifid_flush=0, idex_bubble=0.
- Invariant: ifid_flush and ifid_en are never both 1, except that the flush wins during a branch redirect (ifid_en=1 then).

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, two CNT_W counters exist, both cleared by reset and wrapping at 2^CNT_W-1 to 0:
  - stall_cycles increments every cycle with pc_en=0 while not in reset.
  - flush_count increments on each branch redirect.
- When undefined, the counter ports and logic are absent and the counters add no area.

Decomposition:
- Shared package pipe_pkg holds:
  - the state enum hz_state_t (3-bit);
  - the constant REG_ZERO=0;
  - the NOP encoding used by pipeline registers on flush.
- The hazard comparator is a natural sub-module: lu_hazard_det, purely combinational with REG_ADDR_W as a parameter.
- The FSM and the counters stay in the top module.

Test Plan:
- Load-use, default parameters: ex_mem_read=1, ex_rd=3, id_rs1=3, id_use_rs1=1 for one cycle. Expect one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then a normal cycle. Repeat with ex_rd=0: expect no stall.
- LOAD_USE_STALL=3: same stimulus. Expect state 1 for 2 cycles, a 3-cycle stall in total, then RUN.
- Branch during load-use: ex_branch_taken=1 with a matching lu_hazard. Expect pc_en=1, ifid_flush=1, idex_bubble=1, then RUN; flush_count increments by 1.
- Data miss: mem_req=1, mem_ready=0 for 4 cycles, with ex_branch_taken=1 held throughout. Expect all enables 0 for 4 cycles. On the mem_ready cycle, expect the redirect outputs.
- Fetch miss then reset: imem_valid=0 for 2 cycles gives ifid_flush=1, pc_en=0, state 2. Asserting reset in the second cycle gives the reset outputs, then RUN. stall_cycles counts 1 before reset clears it.
- Counter wrap with CNT_W=4 and 17 stall cycles: expect stall_cycles=1.
